// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the datapath core.
//   DP_DATA_W : default data width for every register, bus and ALU operand
//   aluOp_e   : ALU operation codes (13-15 are unused and produce zero)
//   AUX_*     : bit positions inside the aux_out bus-drive select
package datapath_pkg;

  localparam int DP_DATA_W = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_NEG  = 4'd9,
    OP_NOT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } aluOp_e;

  localparam int AUX_HI  = 0;
  localparam int AUX_LO  = 1;
  localparam int AUX_ZHI = 2;
  localparam int AUX_ZLO = 3;
  localparam int AUX_MDR = 4;
  localparam int AUX_IN  = 5;
  localparam int AUX_W   = 6;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiplier / divider, one bit per cycle.
// Optional feature macro: DATAPATH_DIV_EN (adds the restoring divider and the
// isDiv port; without it only MUL exists).
// Ports:
//   clk, clr      clock, synchronous active-high clear
//   start         launch; operands a/b sampled on this edge (ignored when busy)
//   isDiv         1 = divide a by b, 0 = multiply (only with DATAPATH_DIV_EN)
//   a, b          signed operands (a = Y, b = bus)
//   busy          high for exactly DATA_W cycles after an accepted start
//   done          high during the last busy cycle
//   result        {hi, lo}; valid while done is high, captured by the owner
//                 on the edge that ends the done cycle
// Handshake: start is only honoured while busy is low; once accepted the unit
// runs to completion (or until clr) and the owner takes result when done=1.
module muldiv_unit
  import datapath_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
`ifdef DATAPATH_DIV_EN
  input  logic                  isDiv,
`endif
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  // Two-state FSM; the state bit is exported directly as busy.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] accHi;   // partial product high half / partial remainder
  logic [DATA_W-1:0] accLo;   // multiplier bits / dividend-then-quotient bits
  logic [DATA_W-1:0] opnd;    // multiplicand magnitude / divisor magnitude
  logic              signA;
  logic              signB;

  logic [DATA_W-1:0] magA;
  logic [DATA_W-1:0] magB;
  logic [DATA_W:0]   mulSum;
  logic [DATA_W-1:0] nextHi;
  logic [DATA_W-1:0] nextLo;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] mulRes;

  assign magA = a[DATA_W-1] ? -a : a;
  assign magB = b[DATA_W-1] ? -b : b;

`ifdef DATAPATH_DIV_EN
  logic              divOp;
  logic              divZero;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W:0]   divShift;
  logic [DATA_W:0]   divDiff;
  logic [DATA_W-1:0] quoFix;
  logic [DATA_W-1:0] remFix;
`endif

  // One iteration step; its output is also the final answer on the last cycle,
  // so the result is ready exactly when done is high.
  always_comb begin
    mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    nextHi = mulSum[DATA_W:1];
    nextLo = {mulSum[0], accLo[DATA_W-1:1]};
`ifdef DATAPATH_DIV_EN
    divShift = {accHi, accLo[DATA_W-1]};
    divDiff  = divShift - {1'b0, opnd};
    if (divOp) begin
      if (!divDiff[DATA_W]) begin
        nextHi = divDiff[DATA_W-1:0];
        nextLo = {accLo[DATA_W-2:0], 1'b1};
      end else begin
        nextHi = divShift[DATA_W-1:0];
        nextLo = {accLo[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  assign prod   = {nextHi, nextLo};
  assign mulRes = (signA ^ signB) ? -prod : prod;

`ifdef DATAPATH_DIV_EN
  // Quotient truncates toward zero; remainder carries the dividend's sign.
  assign quoFix = (signA ^ signB) ? -nextLo : nextLo;
  assign remFix = signA ? -nextHi : nextHi;
  always_comb begin
    result = mulRes;
    if (divOp) begin
      if (divZero) result = {dividend, {DATA_W{1'b1}}};
      else         result = {remFix, quoFix};
    end
  end
`else
  assign result = mulRes;
`endif

  assign busy = (state == ST_RUN);
  assign done = (state == ST_RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      accHi <= '0;
      accLo <= '0;
      opnd  <= '0;
      signA <= 1'b0;
      signB <= 1'b0;
`ifdef DATAPATH_DIV_EN
      divOp    <= 1'b0;
      divZero  <= 1'b0;
      dividend <= '0;
`endif
    end else if (state == ST_IDLE) begin
      if (start) begin
        state <= ST_RUN;
        cnt   <= '0;
        accHi <= '0;
        signA <= a[DATA_W-1];
        signB <= b[DATA_W-1];
`ifdef DATAPATH_DIV_EN
        divOp    <= isDiv;
        divZero  <= (b == '0);
        dividend <= a;
        if (isDiv) begin
          accLo <= magA;
          opnd  <= magB;
        end else begin
          accLo <= magB;
          opnd  <= magA;
        end
`else
        accLo <= magB;
        opnd  <= magA;
`endif
      end
    end else begin
      accHi <= nextHi;
      accLo <= nextLo;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) state <= ST_IDLE;
    end
  end

endmodule

// File: rtl/datapath_core.sv
// datapath_core: single-bus CPU datapath (register file, Y/Z/Hi/Lo, MDR,
// in/out ports, ALU and multicycle MUL/DIV).
// Optional feature macro: DATAPATH_DIV_EN (enables DIV; otherwise DIV start
// is rejected through ill_op).
// Ports:
//   clk, clr                clock, synchronous active-high clear
//   reg_out / aux_out       bus-drive selects; lowest index wins, reg_out first
//   reg_in                  per-register bus load enables
//   hi_in lo_in y_in out_in bus load enables for Hi, Lo, Y, OutPort
//   alu_op, z_in            ALU op (A=Y, B=bus); z_in loads single-cycle result
//   start, busy, done       MUL/DIV launch and status; ill_op flags bad start
//   mdr_in, mdr_rd, mem_din MDR load, source select (1=mem_din), memory data
//   mdr_q, in_port, out_port, bus   MDR value, external I/O, bus observation
module datapath_core
  import datapath_pkg::*;
#(
  parameter int DATA_W  = DP_DATA_W,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREGS-1:0]  reg_out,
  input  logic [AUX_W-1:0]  aux_out,
  input  logic [NREGS-1:0]  reg_in,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              y_in,
  input  logic              out_in,
  input  logic [3:0]        alu_op,
  input  logic              z_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ill_op,
  input  logic              mdr_in,
  input  logic              mdr_rd,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mdr_q,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] bus
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] regFile [NREGS];
  logic [DATA_W-1:0] yReg;
  logic [DATA_W-1:0] zHi;
  logic [DATA_W-1:0] zLo;
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;
  logic [DATA_W-1:0] mdrReg;
  logic [DATA_W-1:0] outReg;
  logic              illOpQ;

  logic [DATA_W-1:0]   busVal;
  logic                busFound;
  logic [DATA_W-1:0]   aluRes;
  logic [SH_W-1:0]     shAmt;
  logic                isMulDiv;
  logic                mdStart;
  logic                mdBusy;
  logic                mdDone;
  logic [2*DATA_W-1:0] mdResult;

  // Priority bus: first active select in reg_out[0..], then aux_out[0..].
  always_comb begin
    busVal   = '0;
    busFound = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (!busFound && reg_out[i]) begin
        busVal   = (i == 0 && R0_ZERO != 0) ? '0 : regFile[i];
        busFound = 1'b1;
      end
    end
    for (int j = 0; j < AUX_W; j++) begin
      if (!busFound && aux_out[j]) begin
        busFound = 1'b1;
        case (j)
          AUX_HI:  busVal = hiReg;
          AUX_LO:  busVal = loReg;
          AUX_ZHI: busVal = zHi;
          AUX_ZLO: busVal = zLo;
          AUX_MDR: busVal = mdrReg;
          default: busVal = in_port;
        endcase
      end
    end
  end

  assign shAmt = busVal[SH_W-1:0];

  // Single-cycle ALU: A = Y, B = bus; unary ops act on B.
  always_comb begin
    aluRes = '0;
    case (alu_op)
      OP_ADD:  aluRes = yReg + busVal;
      OP_SUB:  aluRes = yReg - busVal;
      OP_AND:  aluRes = yReg & busVal;
      OP_OR:   aluRes = yReg | busVal;
      OP_SHR:  aluRes = yReg >> shAmt;
      OP_SHRA: aluRes = DATA_W'($signed(yReg) >>> shAmt);
      OP_SHL:  aluRes = yReg << shAmt;
      // A shift by DATA_W yields zero, so shAmt == 0 needs no special case.
      OP_ROR:  aluRes = (yReg >> shAmt) | (yReg << (DATA_W - int'(shAmt)));
      OP_ROL:  aluRes = (yReg << shAmt) | (yReg >> (DATA_W - int'(shAmt)));
      OP_NEG:  aluRes = -busVal;
      OP_NOT:  aluRes = ~busVal;
      default: aluRes = '0;
    endcase
  end

`ifdef DATAPATH_DIV_EN
  assign isMulDiv = (alu_op == OP_MUL) || (alu_op == OP_DIV);
`else
  assign isMulDiv = (alu_op == OP_MUL);
`endif
  assign mdStart = start && !mdBusy && isMulDiv;

  muldiv_unit #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .start  (mdStart),
`ifdef DATAPATH_DIV_EN
    .isDiv  (alu_op == OP_DIV),
`endif
    .a      (yReg),
    .b      (busVal),
    .busy   (mdBusy),
    .done   (mdDone),
    .result (mdResult)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
      yReg   <= '0;
      zHi    <= '0;
      zLo    <= '0;
      hiReg  <= '0;
      loReg  <= '0;
      mdrReg <= '0;
      outReg <= '0;
      illOpQ <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_in[i]) regFile[i] <= busVal;
      end
      if (y_in)   yReg   <= busVal;
      if (hi_in)  hiReg  <= busVal;
      if (lo_in)  loReg  <= busVal;
      if (out_in) outReg <= busVal;
      if (mdr_in) mdrReg <= mdr_rd ? mem_din : busVal;
      // Multicycle result owns Z while busy; z_in is ignored then.
      if (mdDone) begin
        zHi <= mdResult[2*DATA_W-1:DATA_W];
        zLo <= mdResult[DATA_W-1:0];
      end else if (z_in && !mdBusy) begin
        zHi <= '0;
        zLo <= aluRes;
      end
      illOpQ <= start && !mdBusy && !isMulDiv;
    end
  end

  assign busy     = mdBusy;
  assign done     = mdDone;
  assign ill_op   = illOpQ;
  assign mdr_q    = mdrReg;
  assign out_port = outReg;
  assign bus      = busVal;

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;
  import datapath_pkg::*;

  localparam int W  = 32;
  localparam int NR = 16;

  logic          clk;
  logic          clr;
  logic [NR-1:0] reg_out;
  logic [5:0]    aux_out;
  logic [NR-1:0] reg_in;
  logic          hi_in, lo_in, y_in, out_in;
  logic [3:0]    alu_op;
  logic          z_in, start;
  logic          busy, done, ill_op;
  logic          mdr_in, mdr_rd;
  logic [W-1:0]  mem_din, mdr_q, in_port, out_port, bus;

  datapath_core #(.DATA_W(W), .NREGS(NR), .R0_ZERO(1)) dut (
    .clk(clk), .clr(clr), .reg_out(reg_out), .aux_out(aux_out), .reg_in(reg_in),
    .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .out_in(out_in), .alu_op(alu_op),
    .z_in(z_in), .start(start), .busy(busy), .done(done), .ill_op(ill_op),
    .mdr_in(mdr_in), .mdr_rd(mdr_rd), .mem_din(mem_din), .mdr_q(mdr_q),
    .in_port(in_port), .out_port(out_port), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_out = '0; aux_out = '0; reg_in = '0;
    hi_in = 0; lo_in = 0; y_in = 0; out_in = 0;
    alu_op = '0; z_in = 0; start = 0;
    mdr_in = 0; mdr_rd = 0; mem_din = '0; in_port = '0;
  endtask

  task automatic load_reg(input int idx, input logic [W-1:0] val);
    in_port = val; aux_out = 6'(1 << AUX_IN); reg_in = NR'(1) << idx;
    tick();
    idle();
  endtask

  task automatic load_y(input logic [W-1:0] val);
    in_port = val; aux_out = 6'(1 << AUX_IN); y_in = 1;
    tick();
    idle();
  endtask

  task automatic read_z(output logic [63:0] z);
    aux_out = 6'(1 << AUX_ZHI); #1 z[63:32] = bus;
    aux_out = 6'(1 << AUX_ZLO); #1 z[31:0]  = bus;
    aux_out = '0;
  endtask

  task automatic read_reg(input int idx, output logic [W-1:0] v);
    reg_out = NR'(1) << idx; #1 v = bus;
    reg_out = '0;
  endtask

  task automatic alu_check(input string tag, input logic [3:0] op, input int src,
                           input logic [W-1:0] exp);
    logic [63:0] z;
    reg_out = NR'(1) << src; alu_op = op; z_in = 1;
    tick();
    idle();
    read_z(z);
    check(tag, z, {32'h0, exp});
  endtask

  // Launch MUL/DIV with Y already loaded; b is driven onto the bus via in_port.
  // A start+z_in is injected in busy cycle 5 and must be ignored.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] b);
    int bc, dc, di;
    logic ill;
    logic [63:0] z;
    bc = 0; dc = 0; di = 0; ill = 0;
    in_port = b; aux_out = 6'(1 << AUX_IN); alu_op = op; start = 1;
    tick();
    idle();
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      bc++;
      if (done) begin dc++; di = bc; end
      ill = ill | ill_op;
      if (bc == 5) begin start = 1; alu_op = OP_ADD; z_in = 1; end
      else begin start = 0; z_in = 0; alu_op = '0; end
      tick();
    end
    ill = ill | ill_op;
    idle();
    check({tag, " busy cycles"}, 64'(bc), 64'd32);
    check({tag, " done pulses"}, 64'(dc), 64'd1);
    check({tag, " done on last busy"}, 64'(di), 64'd32);
    check({tag, " no ill_op while busy"}, 64'(ill), 64'd0);
    read_z(z);
    if (exp_q.size() != 0) check({tag, " Z"}, z, exp_q.pop_front());
    else check({tag, " expected queue empty"}, 64'(exp_q.size()), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;
    logic [63:0]  z;
    int           doneSeen;

    idle();
    clr = 1;
    // A load requested together with clr must lose.
    in_port = 32'h5; aux_out = 6'(1 << AUX_IN); reg_in = NR'(1) << 3; y_in = 1;
    tick();
    tick();
    idle();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset ill_op", 64'(ill_op), 64'd0);
    clr = 0;
    check("reset out_port", 64'(out_port), 64'd0);
    check("reset mdr_q", 64'(mdr_q), 64'd0);
    #1 check("idle bus zero", 64'(bus), 64'd0);
    read_z(z);
    check("reset Z", z, 64'd0);
    read_reg(3, v);
    check("clr beats reg load", 64'(v), 64'd0);

    // Register loads
    load_reg(3, 32'd7);
    load_reg(5, 32'd9);
    load_reg(1, 32'h1111_1111);
    load_reg(2, 32'h2222_2222);
    read_reg(5, v);
    check("R5 on bus", 64'(v), 64'd9);

    // Y <- R3, ADD with bus = R5
    reg_out = NR'(1) << 3; y_in = 1;
    tick();
    idle();
    alu_check("ADD 7+9", OP_ADD, 5, 32'd16);
    alu_check("SUB 7-9", OP_SUB, 5, 32'hFFFF_FFFE);
    alu_check("AND 7&9", OP_AND, 5, 32'd1);
    alu_check("SHL 7<<9", OP_SHL, 5, 32'd3584);
    alu_check("op13 zero", 4'd13, 5, 32'd0);
    load_y(32'h8000_0001);
    alu_check("ROL by 9", OP_ROL, 5, 32'h0000_0300);
    alu_check("SHRA by 9", OP_SHRA, 5, 32'hFFC0_0000);

    // Bus priority
    reg_out = (NR'(1) << 1) | (NR'(1) << 2);
    #1 check("bus R1 over R2", 64'(bus), 64'h1111_1111);
    reg_out = NR'(1);
    #1 check("R0 reads zero", 64'(bus), 64'd0);
    reg_out = NR'(1) << 2; aux_out = 6'(1 << AUX_IN); in_port = 32'h1234;
    #1 check("reg_out before aux_out", 64'(bus), 64'h2222_2222);
    idle();

    // Multiple loads, Hi, OutPort, MDR
    in_port = 32'hA5A5_0001; aux_out = 6'(1 << AUX_IN);
    reg_in = (NR'(1) << 6) | (NR'(1) << 7); hi_in = 1; out_in = 1;
    tick();
    idle();
    read_reg(6, v);
    check("multi load R6", 64'(v), 64'hA5A5_0001);
    read_reg(7, v);
    check("multi load R7", 64'(v), 64'hA5A5_0001);
    aux_out = 6'(1 << AUX_HI);
    #1 check("Hi load", 64'(bus), 64'hA5A5_0001);
    check("out_port load", 64'(out_port), 64'hA5A5_0001);
    idle();
    mdr_in = 1; mdr_rd = 1; mem_din = 32'hDEAD_BEEF;
    tick();
    idle();
    check("MDR from mem", 64'(mdr_q), 64'hDEAD_BEEF);
    aux_out = 6'(1 << AUX_MDR);
    #1 check("MDR on bus", 64'(bus), 64'hDEAD_BEEF);
    idle();

    // MUL -6 * 4
    load_y(32'hFFFF_FFFA);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFE8);
    run_md("MUL", OP_MUL, 32'd4);

`ifdef DATAPATH_DIV_EN
    load_y(32'hFFFF_FFF9);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    run_md("DIV -7/2", OP_DIV, 32'd2);
    exp_q.push_back(64'hFFFF_FFF9_FFFF_FFFF);
    run_md("DIV by 0", OP_DIV, 32'd0);
`else
    load_y(32'hFFFF_FFF9);
    in_port = 32'd2; aux_out = 6'(1 << AUX_IN); alu_op = OP_DIV; start = 1;
    tick();
    idle();
    check("DIV off ill_op", 64'(ill_op), 64'd1);
    check("DIV off busy", 64'(busy), 64'd0);
    tick();
    check("DIV off ill_op pulse", 64'(ill_op), 64'd0);
    check("DIV off busy later", 64'(busy), 64'd0);
    read_z(z);
    check("DIV off Z unchanged", z, 64'hFFFF_FFFF_FFFF_FFE8);
`endif

    // start with a single-cycle op
    alu_op = OP_ADD; start = 1;
    tick();
    idle();
    check("ADD start ill_op", 64'(ill_op), 64'd1);
    check("ADD start busy", 64'(busy), 64'd0);
    tick();
    check("ADD start ill_op clears", 64'(ill_op), 64'd0);

    // clr at busy cycle 10 aborts MUL
    load_y(32'hFFFF_FFFA);
    in_port = 32'd4; aux_out = 6'(1 << AUX_IN); alu_op = OP_MUL; start = 1;
    tick();
    idle();
    for (int c = 0; c < 9; c++) tick();
    check("busy at cycle 10", 64'(busy), 64'd1);
    clr = 1;
    tick();
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    clr = 0;
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) doneSeen++;
      tick();
    end
    check("abort no done later", 64'(doneSeen), 64'd0);
    read_z(z);
    check("abort Z zero", z, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog: the bench must always end.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every register, bus and ALU operand.
REQ-002 SHALL have parameter NREGS, default 16, general-purpose register count (power of two, 2..32).
REQ-003 SHALL have parameter R0_ZERO, default 1, meaning R0 reads as zero on the bus when 1.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge
- clr  in  1  reset, synchronous, active-high
- reg_out  in  NREGS  one-hot bus-drive select for R[i]
- aux_out  in  6  bus-drive select: bit0 Hi, bit1 Lo, bit2 Zhi, bit3 Zlo, bit4 MDR, bit5 InPort
- reg_in  in  NREGS  per-register load-from-bus enables
- hi_in, lo_in, y_in, out_in  in  1 each  load Hi/Lo/Y/OutPort from bus
- alu_op  in  4  operation code
- z_in  in  1  load Z from ALU (single-cycle ops)
- start  in  1  launch MUL/DIV from Y and bus
- busy  out  1  multicycle unit active
- done  out  1  one-cycle pulse; Z written same edge
- ill_op  out  1  one-cycle pulse on rejected start
- mdr_in, mdr_rd  in  1 each  MDR load enable; source select (1 = mem_din, 0 = bus)
- mem_din  in  DATA_W  memory read data
- mdr_q  out  DATA_W  MDR contents
- in_port  in  DATA_W  external input
- out_port  out  DATA_W  OutPort register
- bus  out  DATA_W  current bus value (observability)

Function
REQ-005 Bus SHALL equal the source with the lowest select index among reg_out then aux_out; zero if no select active.
REQ-006 Each register loaded by an enable SHALL capture bus at the next edge; multiple simultaneous loads SHALL all capture.
REQ-007 ALU A = Y, B = bus; codes ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, NEG 9, NOT 10, MUL 11, DIV 12; 13-15 produce zero.
REQ-008 Shift/rotate amount SHALL be B[$clog2(DATA_W)-1:0]; arithmetic wraps modulo 2^DATA_W.
REQ-009 Single-cycle ops: z_in SHALL load Zlo = result, Zhi = 0.
REQ-010 start with alu_op MUL/DIV and busy=0 SHALL latch operands; busy asserts next cycle for exactly DATA_W cycles; done pulses on the last busy cycle.
REQ-011 MUL: signed two's-complement; Zhi:Zlo = 2*DATA_W-bit product.
REQ-012 DIV: signed, truncating; Zlo = quotient, Zhi = remainder (sign of dividend Y).
REQ-013 DIV by zero SHALL take full latency, giving Zlo = all ones, Zhi = Y.
REQ-014 start while busy=1 SHALL be ignored, with no ill_op; z_in while busy SHALL be ignored.
REQ-015 start with a non-MUL/DIV alu_op SHALL pulse ill_op and not assert busy.

Reset
REQ-016 clr SHALL zero all registers, Y, Z, Hi, Lo, MDR, OutPort; busy, done and ill_op SHALL read 0 the cycle after.
REQ-017 clr during busy SHALL abort the operation: no done, Z unchanged from reset value 0.
REQ-018 clr SHALL take priority over all enables in the same cycle.

Configuration
REQ-019 Macro DATAPATH_DIV_EN defined: DIV implemented per REQ-012/013.
REQ-020 Macro DATAPATH_DIV_EN undefined: no divider logic; start with DIV pulses ill_op, busy stays 0, Z unchanged.

Structure
REQ-021 Package datapath_pkg SHALL hold the alu_op enum, aux_out bit indices and the shared DATA_W default.
REQ-022 Multicycle MUL/DIV SHALL be sub-module muldiv_unit (start/busy/done, 2*DATA_W result); the remainder stays flat.

Verification
REQ-023 Bench SHALL cover, with DATA_W=32:
- R3=7, R5=9; Y<-R3, ADD with bus=R5, z_in -> Zlo=16, Zhi=0
- Y=-6, bus=4, MUL start -> busy for 32 cycles, done pulse, Zhi:Zlo=0xFFFFFFFF_FFFFFFE8
- Y=-7, bus=2, DIV start -> Zlo=0xFFFFFFFD, Zhi=0xFFFFFFFF; bus=0 -> Zlo=0xFFFFFFFF, Zhi=Y
- reg_out R1 and R2 both set, R0_ZERO=1, reg_out R0 set -> bus=R1; then bus=0
- clr at busy cycle 10 -> busy=0 next cycle, no done, Z=0
- DATAPATH_DIV_EN undefined, DIV start -> ill_op one cycle, busy=0; start with ADD -> ill_op
